monitor_c2_violation_reporter: RTL and testbench
================================================

# monitor_c2_violation_reporter

Downstream consumer of the cluster-2 LTL monitor: takes the ten per-property violation lines `ltl0c2`..`ltl9c2` and turns them into timestamped violation events. Each new violation (rising edge of a property line) is recorded in a sticky register and a per-property saturating counter, and is queued in a small event FIFO. A valid/ready report port drains the FIFO, and a level interrupt summarises pending violations for the core-side monitor controller.

## Interface
Parameters:
- `NUM_PROPS`, 10, number of property lines (bit i = `ltl{i}c2`)
- `CNT_W`, 8, width of the per-property saturating counter
- `TS_W`, 16, width of the free-running timestamp
- `FIFO_DEPTH`, 4, event FIFO entries (power of two, ≥2)

Ports:
- `clk`  in  1  single clock
- `reset`  in  1  asynchronous, active-low reset
- `run`  in  1  same `run` that drives the monitor cluster; qualifies events and the timestamp
- `ltl_hit`  in  NUM_PROPS  property lines; bit i = `ltl{i}c2`
- `clear`  in  1  single-cycle pulse that clears stickies, counters, overflow and the FIFO
- `cnt_sel`  in  4  property index for the counter readback
- `cnt_o`  out  CNT_W  counter of property `cnt_sel`, combinational read; 0 if `cnt_sel ≥ NUM_PROPS`
- `sticky_o`  out  NUM_PROPS  sticky violation flags
- `overflow_o`  out  1  sticky flag: an event was dropped because the FIFO was full
- `irq_o`  out  1  registered OR of `sticky_o` and `overflow_o`
- `rpt_valid`  out  1  FIFO head valid
- `rpt_ready`  in  1  consumer accepts the head
- `rpt_prop`  out  4  property index of the head event
- `rpt_multi`  out  1  head event had more than one new edge in the same cycle
- `rpt_ts`  out  TS_W  timestamp of the head event

## Operation
- `hit_q` registers `ltl_hit` every cycle, regardless of `run`.
- New edges: `edge = ltl_hit & ~hit_q & {NUM_PROPS{run}}`.
- Timestamp `ts` increments by 1 each cycle that `run`=1. It wraps modulo 2^TS_W and holds while `run`=0. `clear` does not reset `ts`.
- For each bit i with `edge[i]`:
  - set `sticky[i]`
  - increment `cnt[i]`, saturating at 2^CNT_W−1
- Event push when `edge != 0`:
  - `prop` = lowest set index of `edge`
  - `multi` = popcount(`edge`) > 1
  - `ts` = current `ts` value, before this cycle's increment
  - Only one FIFO entry is pushed per cycle. The other properties that edged in that cycle update only their stickies and counters.
- FIFO full:
  - A push with no pop in the same cycle is dropped and sets `overflow`.
  - Push and pop in the same cycle while full are both accepted; the count is unchanged.
- FIFO empty: `rpt_valid`=0 and the `rpt_*` payload is held at its last value (0 after reset).
- Pop occurs on `rpt_valid & rpt_ready`. `rpt_prop`, `rpt_multi` and `rpt_ts` stay stable while `rpt_valid`=1 and `rpt_ready`=0.
- `clear`:
  - In the cycle it is asserted, `clear` has priority over everything: stickies, counters and `overflow` go to 0, the FIFO is flushed, and any same-cycle edge or pop is discarded.
  - `hit_q` and `ts` still update normally, so a line held high across `clear` does not re-fire.
- Reset (async, `reset`=0): all state goes to 0, including `hit_q`, `ts`, stickies, counters, FIFO pointers and `irq_o`. Reset mid-transfer drops all queued events.

## Timing
- Latency: an edge present on `ltl_hit` in cycle N produces the following in cycle N+1 (registered):
  - `sticky_o` and `cnt_o` updated
  - `rpt_valid`=1, if the FIFO was empty
- `irq_o` rises in cycle N+2, one cycle after the sticky/overflow update.
- Pop throughput: one event per cycle under a continuously asserted `rpt_ready`.
- Outputs after reset release, until the first event: `rpt_valid`=0, `rpt_prop`=0, `rpt_multi`=0, `rpt_ts`=0, `sticky_o`=0, `overflow_o`=0, `irq_o`=0, `cnt_o`=0.

## Structure
- Shared package `monitor_c2_pkg`:
  - `MON_C2_NUM_PROPS`=10
  - `MON_C2_PROP_IDX_W`=4
  - typedef `mon_c2_evt_t` {prop, multi, ts}
  - function `mon_c2_lowest_idx` (priority encoder)
- One sub-module, `monitor_c2_evt_fifo`: a synchronous FIFO of `mon_c2_evt_t` with push/pop/full/empty/flush and simultaneous push+pop when full. Edge detection, counters, stickies and `irq_o` live in the top module.

## Test plan
- Reset, then `run`=1 and `ltl_hit`=0x004 at cycle 5. Expect:
  - cycle 6: `rpt_valid`=1, `rpt_prop`=2, `rpt_ts`=5, `rpt_multi`=0, `sticky_o`=0x004
  - cycle 7: `irq_o`=1
  - A second cycle with `ltl_hit`=0x004 (line held high) produces no new event.
- `ltl_hit` goes 0→0x240 in one cycle. Expect one event with `rpt_prop`=6 and `rpt_multi`=1, `sticky_o`=0x240, and `cnt[6]`=`cnt[9]`=1.
- `rpt_ready`=0 with 5 distinct single-bit edges. Expect:
  - the first 4 events are queued in order
  - the 5th is dropped, `overflow_o`=1, and its sticky and counter are still set
  - then `rpt_ready`=1 and a new edge in the same cycle: push and pop both accepted and the FIFO stays full.
- Toggle `ltl_hit[0]` 300 times with `CNT_W`=8. Expect `cnt_o` (sel 0) = 255, saturated, no wrap. Then a `clear` pulse gives `cnt_o`=0, `sticky_o`=0, `rpt_valid`=0, `irq_o`=0 one cycle later.
- `run`=0 with `ltl_hit` toggling: no events and `ts` frozen. On `run`=1, `ts` resumes from its held value. Force `ts` to 0xFFFF; the next event is stamped 0xFFFF and the following cycle's event is stamped 0x0000.
- Assert `reset`=0 asynchronously mid-cycle with 3 events queued and `rpt_valid`=1. Expect all outputs 0 immediately, and no stale event after release.

Source files
------------

// File: rtl/monitor_c2_pkg.sv
// Shared types and helpers for the cluster-2 monitor violation reporter.
// The event record width is fixed here; the top-level defaults track these values.
package monitor_c2_pkg;

    localparam int MON_C2_NUM_PROPS  = 10;
    localparam int MON_C2_PROP_IDX_W = 4;
    localparam int MON_C2_TS_W       = 16;

    typedef struct packed {
        logic [MON_C2_PROP_IDX_W-1:0] prop;
        logic                         multi;
        logic [MON_C2_TS_W-1:0]       ts;
    } mon_c2_evt_t;

    // Priority encoder: index of the lowest set bit, 0 when none are set.
    function automatic logic [MON_C2_PROP_IDX_W-1:0] mon_c2_lowest_idx(
        input logic [MON_C2_NUM_PROPS-1:0] vec
    );
        logic [MON_C2_PROP_IDX_W-1:0] idx;
        idx = '0;
        for (int i = MON_C2_NUM_PROPS - 1; i >= 0; i--) begin
            if (vec[i]) idx = MON_C2_PROP_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/monitor_c2_violation_reporter_if.sv
// Valid/ready report port carrying one violation event per transfer.
interface monitor_c2_violation_reporter_if;
    import monitor_c2_pkg::*;

    logic                         rpt_valid;
    logic                         rpt_ready;
    logic [MON_C2_PROP_IDX_W-1:0] rpt_prop;
    logic                         rpt_multi;
    logic [MON_C2_TS_W-1:0]       rpt_ts;

    modport master (
        output rpt_valid, rpt_prop, rpt_multi, rpt_ts,
        input  rpt_ready
    );

    modport slave (
        input  rpt_valid, rpt_prop, rpt_multi, rpt_ts,
        output rpt_ready
    );

endinterface

// File: rtl/monitor_c2_evt_fifo.sv
// Synchronous event FIFO with flush; accepts push and pop together even when full.
module monitor_c2_evt_fifo
    import monitor_c2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        push,
    input  logic        pop,
    input  mon_c2_evt_t push_data,
    output mon_c2_evt_t head,
    output logic        full,
    output logic        empty
);

    localparam int PTR_W = $clog2(DEPTH);

    mon_c2_evt_t      mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    // Extra pointer bit distinguishes full from empty when the low bits match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = ((wr_ptr ^ rd_ptr) == {1'b1, {PTR_W{1'b0}}});
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign head    = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/monitor_c2_violation_reporter.sv
// Turns cluster-2 LTL property lines into sticky flags, saturating counters,
// a level interrupt and timestamped events queued on a valid/ready report port.
module monitor_c2_violation_reporter
    import monitor_c2_pkg::*;
#(
    parameter int NUM_PROPS  = MON_C2_NUM_PROPS,
    parameter int CNT_W      = 8,
    parameter int TS_W       = MON_C2_TS_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic [NUM_PROPS-1:0] ltl_hit,
    input  logic                 clear,
    input  logic [3:0]           cnt_sel,
    output logic [CNT_W-1:0]     cnt_o,
    output logic [NUM_PROPS-1:0] sticky_o,
    output logic                 overflow_o,
    output logic                 irq_o,
    monitor_c2_violation_reporter_if.master rpt
);

    logic [NUM_PROPS-1:0] hit_q;
    logic [NUM_PROPS-1:0] new_edge;
    logic [NUM_PROPS-1:0] sticky_q;
    logic [CNT_W-1:0]     cnt_q [NUM_PROPS];
    logic [TS_W-1:0]      ts_q;
    logic                 overflow_q;
    logic                 irq_q;
    mon_c2_evt_t          push_evt;
    mon_c2_evt_t          head_evt;
    mon_c2_evt_t          hold_q;
    mon_c2_evt_t          rpt_evt;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 evt_push;
    logic                 evt_pop;

    assign new_edge = ltl_hit & ~hit_q & {NUM_PROPS{run}};

    // clear wins over any same-cycle edge or pop.
    assign evt_push = (|new_edge) & ~clear;
    assign evt_pop  = rpt.rpt_ready & ~fifo_empty & ~clear;

    assign push_evt = '{
        prop:  mon_c2_lowest_idx(new_edge),
        multi: ((new_edge & (new_edge - NUM_PROPS'(1))) != '0),
        ts:    ts_q
    };

    monitor_c2_evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_evt_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (clear),
        .push      (evt_push),
        .pop       (evt_pop),
        .push_data (push_evt),
        .head      (head_evt),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_q      <= '0;
            ts_q       <= '0;
            overflow_q <= 1'b0;
            irq_q      <= 1'b0;
            hold_q     <= '0;
        end else begin
            hit_q <= ltl_hit;
            if (run) ts_q <= ts_q + TS_W'(1);
            // Remember the last head shown so the payload holds once the FIFO drains.
            if (!fifo_empty) hold_q <= head_evt;
            if (clear) begin
                overflow_q <= 1'b0;
            end else if (evt_push && fifo_full && !evt_pop) begin
                overflow_q <= 1'b1;
            end
            irq_q <= ~clear & ((|sticky_q) | overflow_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sticky_q <= '0;
            for (int i = 0; i < NUM_PROPS; i++) cnt_q[i] <= '0;
        end else if (clear) begin
            sticky_q <= '0;
            for (int i = 0; i < NUM_PROPS; i++) cnt_q[i] <= '0;
        end else begin
            sticky_q <= sticky_q | new_edge;
            for (int i = 0; i < NUM_PROPS; i++) begin
                if (new_edge[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_comb begin
        // NOTE: default assigned first so no path leaves cnt_o unassigned (no latch).
        cnt_o = '0;
        if (32'(cnt_sel) < NUM_PROPS) cnt_o = cnt_q[cnt_sel];
    end

    assign rpt_evt       = fifo_empty ? hold_q : head_evt;
    assign rpt.rpt_valid = ~fifo_empty;
    assign rpt.rpt_prop  = rpt_evt.prop;
    assign rpt.rpt_multi = rpt_evt.multi;
    assign rpt.rpt_ts    = rpt_evt.ts;

    assign sticky_o   = sticky_q;
    assign overflow_o = overflow_q;
    assign irq_o      = irq_q;

endmodule

// File: tb/tb_monitor_c2_violation_reporter.sv
// Directed bench for the cluster-2 violation reporter: a rule-level model
// compared every cycle, plus hand-computed literal expectations.
module tb_monitor_c2_violation_reporter;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic [9:0] ltl_hit;
    logic       clear;
    logic [3:0] cnt_sel;
    logic [7:0] cnt_o;
    logic [9:0] sticky_o;
    logic       overflow_o;
    logic       irq_o;

    monitor_c2_violation_reporter_if rpt_if ();

    monitor_c2_violation_reporter dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .ltl_hit    (ltl_hit),
        .clear      (clear),
        .cnt_sel    (cnt_sel),
        .cnt_o      (cnt_o),
        .sticky_o   (sticky_o),
        .overflow_o (overflow_o),
        .irq_o      (irq_o),
        .rpt        (rpt_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: event list, sticky set, per-property counts, timestamp.
    typedef struct {
        int prop;
        bit multi;
        int ts;
    } ev_t;

    ev_t      mq[$];
    ev_t      m_last;
    bit [9:0] m_sticky;
    int       m_cnt[10];
    bit       m_ovf;
    bit       m_irq;
    int       m_ts;
    bit [9:0] m_hitq;
    bit [9:0] m_edges;
    bit       m_irq_next;
    ev_t      m_new;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            m_last   = '{0, 0, 0};
            m_sticky = '0;
            for (int i = 0; i < 10; i++) m_cnt[i] = 0;
            m_ovf    = 0;
            m_irq    = 0;
            m_ts     = 0;
            m_hitq   = '0;
        end else begin
            m_edges    = run ? (ltl_hit & ~m_hitq) : 10'h000;
            m_irq_next = clear ? 1'b0 : ((m_sticky != 0) || m_ovf);
            if (mq.size() > 0) m_last = mq[0];
            if (clear) begin
                mq.delete();
                m_sticky = '0;
                for (int i = 0; i < 10; i++) m_cnt[i] = 0;
                m_ovf = 0;
            end else begin
                if (rpt_if.rpt_ready && mq.size() > 0) void'(mq.pop_front());
                for (int i = 0; i < 10; i++) begin
                    if (m_edges[i]) begin
                        m_sticky[i] = 1'b1;
                        if (m_cnt[i] < 255) m_cnt[i]++;
                    end
                end
                if (m_edges != 0) begin
                    m_new.prop = 0;
                    for (int i = 9; i >= 0; i--) if (m_edges[i]) m_new.prop = i;
                    m_new.multi = ($countones(m_edges) > 1);
                    m_new.ts    = m_ts;
                    if (mq.size() < 4) mq.push_back(m_new);
                    else m_ovf = 1;
                end
            end
            m_irq  = m_irq_next;
            m_hitq = ltl_hit;
            if (run) m_ts = (m_ts + 1) % 65536;
        end
    end

    // Per-cycle comparison against the model on the falling edge.
    ev_t exp_head;
    always @(negedge clk) begin
        exp_head = (mq.size() > 0) ? mq[0] : m_last;
        check("m_rpt_valid", rpt_if.rpt_valid, (mq.size() > 0));
        check("m_rpt_prop",  rpt_if.rpt_prop,  exp_head.prop);
        check("m_rpt_multi", rpt_if.rpt_multi, exp_head.multi);
        check("m_rpt_ts",    rpt_if.rpt_ts,    exp_head.ts);
        check("m_sticky",    sticky_o,         m_sticky);
        check("m_overflow",  overflow_o,       m_ovf);
        check("m_irq",       irq_o,            m_irq);
        check("m_cnt_o",     cnt_o,            (cnt_sel < 10) ? m_cnt[cnt_sel] : 0);
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    logic [15:0] ts_a;
    logic [15:0] ts_b;

    initial begin
        reset   = 1'b0;
        run     = 1'b0;
        ltl_hit = '0;
        clear   = 1'b0;
        cnt_sel = '0;
        rpt_if.rpt_ready = 1'b0;
        cyc(3);
        check("rst_valid",  rpt_if.rpt_valid, 0);
        check("rst_sticky", sticky_o, 0);
        check("rst_irq",    irq_o, 0);
        reset = 1'b1;

        // Single edge at ts 5.
        run = 1'b1;
        cyc(5);
        ltl_hit = 10'h004;
        cyc(1);
        check("t1_valid",  rpt_if.rpt_valid, 1);
        check("t1_prop",   rpt_if.rpt_prop, 2);
        check("t1_ts",     rpt_if.rpt_ts, 5);
        check("t1_multi",  rpt_if.rpt_multi, 0);
        check("t1_sticky", sticky_o, 10'h004);
        check("t1_irq_n1", irq_o, 0);
        cyc(1);
        check("t1_irq",    irq_o, 1);
        cnt_sel = 4'd2;
        #1;
        check("t1_cnt2",   cnt_o, 1);
        rpt_if.rpt_ready = 1'b1;
        cyc(1);
        check("t1_drained", rpt_if.rpt_valid, 0);
        check("t1_hold",    rpt_if.rpt_prop, 2);

        // Two simultaneous edges.
        ltl_hit = 10'h000;
        cyc(1);
        ltl_hit = 10'h240;
        cyc(1);
        check("t2_prop",   rpt_if.rpt_prop, 6);
        check("t2_multi",  rpt_if.rpt_multi, 1);
        check("t2_sticky", sticky_o, 10'h244);
        cnt_sel = 4'd6;
        #1 check("t2_cnt6", cnt_o, 1);
        cnt_sel = 4'd9;
        #1 check("t2_cnt9", cnt_o, 1);
        cnt_sel = 4'd12;
        #1 check("t2_cnt_oob", cnt_o, 0);
        ltl_hit = 10'h000;
        cyc(2);

        // Overflow with a stalled consumer.
        rpt_if.rpt_ready = 1'b0;
        foreach (ltl_hit[i]) begin end
        ltl_hit = 10'h001; cyc(1);
        ltl_hit = 10'h002; cyc(1);
        ltl_hit = 10'h008; cyc(1);
        ltl_hit = 10'h010; cyc(1);
        ltl_hit = 10'h020; cyc(1);
        ltl_hit = 10'h000; cyc(1);
        check("t3_valid",  rpt_if.rpt_valid, 1);
        check("t3_head",   rpt_if.rpt_prop, 0);
        check("t3_ovf",    overflow_o, 1);
        check("t3_sticky", sticky_o, 10'h27F);
        cnt_sel = 4'd5;
        #1 check("t3_cnt5", cnt_o, 1);
        rpt_if.rpt_ready = 1'b1;
        ltl_hit = 10'h080;
        cyc(1);
        check("t3_pp_head", rpt_if.rpt_prop, 1);
        ltl_hit = 10'h000;
        cyc(1); check("t3_drain3", rpt_if.rpt_prop, 3);
        cyc(1); check("t3_drain4", rpt_if.rpt_prop, 4);
        cyc(1); check("t3_drain7", rpt_if.rpt_prop, 7);
        check("t3_drain7v", rpt_if.rpt_valid, 1);
        cyc(1); check("t3_empty", rpt_if.rpt_valid, 0);

        // Counter saturation, then clear with a same-cycle edge.
        cnt_sel = 4'd0;
        for (int k = 0; k < 300; k++) begin
            ltl_hit = 10'h001; cyc(1);
            ltl_hit = 10'h000; cyc(1);
        end
        check("t4_sat",     cnt_o, 255);
        check("t4_irq_pre", irq_o, 1);
        clear   = 1'b1;
        ltl_hit = 10'h100;
        cyc(1);
        clear = 1'b0;
        check("t4_cnt",    cnt_o, 0);
        check("t4_sticky", sticky_o, 0);
        check("t4_valid",  rpt_if.rpt_valid, 0);
        check("t4_irq",    irq_o, 0);
        check("t4_ovf",    overflow_o, 0);
        cyc(1);
        check("t4_nofire", sticky_o, 0);
        ltl_hit = 10'h000;
        cyc(1);

        // Timestamp frozen while run is low.
        rpt_if.rpt_ready = 1'b0;
        ltl_hit = 10'h002; cyc(1);
        run = 1'b0;
        ltl_hit = 10'h000; cyc(1);
        ltl_hit = 10'h002; cyc(1);
        ltl_hit = 10'h000; cyc(1);
        ltl_hit = 10'h002; cyc(1);
        ltl_hit = 10'h000; cyc(2);
        check("t5_sticky_run0", sticky_o, 10'h002);
        run = 1'b1;
        ltl_hit = 10'h002; cyc(1);
        ltl_hit = 10'h000; cyc(1);
        ts_a = rpt_if.rpt_ts;
        rpt_if.rpt_ready = 1'b1;
        cyc(1);
        ts_b = rpt_if.rpt_ts;
        check("t5_ts_delta", 32'(ts_b - ts_a), 1);
        check("t5_valid_b",  rpt_if.rpt_valid, 1);
        cyc(1);
        check("t5_empty",    rpt_if.rpt_valid, 0);

        // Timestamp wrap.
        rpt_if.rpt_ready = 1'b0;
        while (m_ts != 32'hFFFF) cyc(1);
        ltl_hit = 10'h001; cyc(1);
        ltl_hit = 10'h003; cyc(1);
        ltl_hit = 10'h000; cyc(1);
        check("t6_prop0", rpt_if.rpt_prop, 0);
        check("t6_tsmax", rpt_if.rpt_ts, 16'hFFFF);
        rpt_if.rpt_ready = 1'b1;
        cyc(1);
        check("t6_prop1", rpt_if.rpt_prop, 1);
        check("t6_ts0",   rpt_if.rpt_ts, 0);
        cyc(1);

        // Asynchronous reset with events queued.
        rpt_if.rpt_ready = 1'b0;
        ltl_hit = 10'h004; cyc(1);
        ltl_hit = 10'h00C; cyc(1);
        ltl_hit = 10'h01C; cyc(1);
        ltl_hit = 10'h000; cyc(1);
        check("t7_pre_valid", rpt_if.rpt_valid, 1);
        #1 reset = 1'b0;
        #1;
        check("t7_valid",  rpt_if.rpt_valid, 0);
        check("t7_prop",   rpt_if.rpt_prop, 0);
        check("t7_multi",  rpt_if.rpt_multi, 0);
        check("t7_ts",     rpt_if.rpt_ts, 0);
        check("t7_sticky", sticky_o, 0);
        check("t7_ovf",    overflow_o, 0);
        check("t7_irq",    irq_o, 0);
        check("t7_cnt",    cnt_o, 0);
        cyc(2);
        reset = 1'b1;
        rpt_if.rpt_ready = 1'b1;
        cyc(4);
        check("t7_nostale", rpt_if.rpt_valid, 0);
        check("t7_post_sticky", sticky_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
